uop_issue_queue: RTL and testbench
==================================

# uop_issue_queue

In-order issue buffer that feeds operand bundles to the execution lanes built from `microop_unit`. It accepts decoded micro-ops on a valid/ready input port and holds them in a small FIFO. Ops leave the FIFO through a valid/ready issue port, and the number of ops in flight is capped by tracking completions returned from the lanes. It is the producer side of the lane operand interface: it drives `op`, `a`, `b` and `shamt` and consumes completions.

## Interface
- `W`, 64, operand width; must match the lane `W`.
- `DEPTH`, 4, number of FIFO entries; power of two, ≥2.
- `TAG_W`, 4, width of the op tag carried alongside each entry.
- `MAX_INFLIGHT`, 2, maximum number of issued ops still awaiting completion; range 1..2^TAG_W.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous flush; discards all FIFO contents.
- `in_valid` / `in_ready`  in/out  1  enqueue handshake.
- `in_op`  in  `uop_pkg::op_t`  micro-op code.
- `in_a`, `in_b`  in  W  operands.
- `in_shamt`  in  $clog2(W)  shift amount.
- `in_tag`  in  TAG_W  op tag.
- `iss_valid` / `iss_ready`  out/in  1  issue handshake toward the lanes.
- `iss_op`, `iss_a`, `iss_b`, `iss_shamt`, `iss_tag`  out  same widths as the `in_*` fields  head entry.
- `cmp_valid`  in  1  one lane completion this cycle.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `inflight`  out  $clog2(MAX_INFLIGHT)+1  number of issued ops not yet completed.
- `nop_drop`  out  1  one-cycle pulse when a NOP head entry is retired.
- `err_cmp`  out  1  sticky flag: a completion arrived while `inflight`==0.

## Operation
- **Storage:** circular FIFO with read/write pointers of $clog2(DEPTH) bits plus a separate occupancy counter. Pointers wrap modulo DEPTH.
- **Push:** on `in_valid && in_ready`, the entry is written at the write pointer.
  - `in_ready` = (`count` < DEPTH) && !`flush`.
  - No same-cycle full bypass: when the FIFO is full, a push is refused even if a pop happens in the same cycle.
- **Head is a NOP (`in_op`==OP_NOP):** the entry is popped without issue on the next cycle it is at the head.
  - `nop_drop` pulses for that cycle.
  - `iss_valid` is held low for that cycle.
  - `inflight` is unchanged.
- **Head is not a NOP:** `iss_valid` = (`count`>0) && (`inflight` < MAX_INFLIGHT) && !`flush`.
  - On `iss_valid && iss_ready`: pop the entry and increment `inflight`.
- **Completion:** `cmp_valid` decrements `inflight`.
  - Issue and completion in the same cycle leave `inflight` unchanged.
  - `cmp_valid` with `inflight`==0 and no issue in that cycle: `inflight` stays 0 and `err_cmp` is set. `err_cmp` clears only on reset.
- **Push and pop in the same cycle:** `count` is unchanged and both pointers advance.
- **`flush`:** sets pointers and `count` to 0; any push or pop in that cycle is ignored.
  - Does not change `inflight`; ops already issued still complete.
- **Reset:** may assert at any time, including mid-handshake, and forces every output to its reset value immediately.
  - `in_ready`=0 during reset; it goes to 1 in the first cycle after release.
  - `iss_valid`=0, `count`=0, `inflight`=0, `nop_drop`=0, `err_cmp`=0.
  - `iss_*` data outputs are 0.

## Timing
- An entry pushed in cycle N can be issued or NOP-dropped no earlier than cycle N+1; there is no combinational input-to-issue path.
- `iss_*` data outputs come straight from the head storage, read through a registered pointer.
- While `iss_valid && !iss_ready`, `iss_*` stay stable and `iss_valid` does not drop, except on `flush` or reset.
- `in_ready` depends only on registered state and `flush`, never on `iss_ready` or `cmp_valid`.
- `iss_valid` depends on registered state and `flush` only; `iss_ready` does not feed back into it.
- Sustained throughput is one issue per cycle when `MAX_INFLIGHT` is not limiting.

## Structure
- `uop_pkg`:
  - already provides `op_t` and `OP_NOP`;
  - add the `uop_req_t` packed struct {op, a, b, shamt, tag}, parameterized through package constants for W=64 and TAG_W=4, used for FIFO entries.
- Sub-module `uop_fifo`: generic DEPTH×entry storage with push/pop/flush and count.
  - `uop_issue_queue` adds NOP dropping, in-flight accounting and the error flag on top of it.

## Test plan
- **Basic issue:** push ADD (a=5, b=7, tag=1) with `iss_ready`=1.
  - `iss_valid` rises the next cycle with a=5, b=7, tag=1; after the issue, `inflight`=1 and `count`=0.
- **Full FIFO:** DEPTH=4, `iss_ready`=0, push 5 ops back to back.
  - `in_ready` drops after the 4th push and `count`=4.
  - The 5th op is accepted only after one pop.
  - Pops return tags 0,1,2,3 in order across pointer wrap-around.
- **In-flight cap:** MAX_INFLIGHT=2, 3 ops queued, `iss_ready`=1, no completions.
  - Exactly 2 ops issue and `iss_valid` goes low.
  - A `cmp_valid` pulse lets the 3rd op issue the following cycle.
- **NOP drop:** queue NOP, SUB.
  - `nop_drop` pulses one cycle with `iss_valid`=0, then SUB issues; `inflight` ends at 1.
- **Flush and spurious completion:** flush with 3 queued and 1 in flight.
  - `count`=0 and `inflight`=1 after the flush.
  - Two `cmp_valid` pulses: `inflight`=0 and `err_cmp`=1.
- **Reset mid-operation:** assert `rst_n`=0 while `iss_valid`=1 and `iss_ready`=0.
  - All outputs go to their reset values immediately.
  - After release, `in_ready`=1 and `err_cmp`=0.

Source files
------------

// File: rtl/uop_pkg.sv
// Shared micro-op types: op codes and the request payload held in the issue FIFO.
package uop_pkg;

   localparam int unsigned UOP_W       = 64;
   localparam int unsigned UOP_TAG_W   = 4;
   localparam int unsigned UOP_SHAMT_W = $clog2(UOP_W);

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_XOR = 4'd5,
      OP_SLL = 4'd6,
      OP_SRL = 4'd7,
      OP_SRA = 4'd8
   } op_t;

   typedef struct packed {
      op_t                    op;
      logic [UOP_W-1:0]       a;
      logic [UOP_W-1:0]       b;
      logic [UOP_SHAMT_W-1:0] shamt;
      logic [UOP_TAG_W-1:0]   tag;
   } uop_req_t;

   // True when the entry carries no work and should be retired without issue.
   function automatic logic is_nop(input uop_req_t r);
      return r.op == OP_NOP;
   endfunction

endpackage

// File: rtl/uop_fifo.sv
// Circular DEPTH-entry store for micro-op requests with push/pop/flush and occupancy.
module uop_fifo
   import uop_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  uop_req_t                 wdata,
   input  logic                     pop,
   output uop_req_t                 rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   uop_req_t             mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   // Flush wins over any handshake in the same cycle.
   always_comb begin
      do_push = push && !flush;
      do_pop  = pop && !flush;
      rdata   = mem[rd_ptr];
   end

   // Entry storage; cleared on reset so the head reads as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally modulo DEPTH; occupancy tracked separately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/uop_issue_queue.sv
// In-order issue buffer: FIFO of micro-ops, NOP dropping, in-flight cap and completion tracking.
module uop_issue_queue
   import uop_pkg::*;
#(
   parameter int unsigned W            = 64,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned TAG_W        = 4,
   parameter int unsigned MAX_INFLIGHT = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  op_t                             in_op,
   input  logic [W-1:0]                    in_a,
   input  logic [W-1:0]                    in_b,
   input  logic [$clog2(W)-1:0]            in_shamt,
   input  logic [TAG_W-1:0]                in_tag,
   output logic                            iss_valid,
   input  logic                            iss_ready,
   output op_t                             iss_op,
   output logic [W-1:0]                    iss_a,
   output logic [W-1:0]                    iss_b,
   output logic [$clog2(W)-1:0]            iss_shamt,
   output logic [TAG_W-1:0]                iss_tag,
   input  logic                            cmp_valid,
   output logic [$clog2(DEPTH):0]          count,
   output logic [$clog2(MAX_INFLIGHT):0]   inflight,
   output logic                            nop_drop,
   output logic                            err_cmp
);

   localparam int unsigned SH_W  = $clog2(W);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned IF_W  = $clog2(MAX_INFLIGHT) + 1;

   uop_req_t wdata;
   uop_req_t head;
   logic     push;
   logic     pop;
   logic     issue;
   logic     has_entry;
   logic     head_nop;
   logic     under_cap;
   logic     rdy_q;

   uop_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (head),
      .count (count)
   );

   // Handshake decode from registered state and flush only; head data straight from storage.
   always_comb begin
      wdata.op    = in_op;
      wdata.a     = UOP_W'(in_a);
      wdata.b     = UOP_W'(in_b);
      wdata.shamt = UOP_SHAMT_W'(in_shamt);
      wdata.tag   = UOP_TAG_W'(in_tag);

      has_entry = (count != '0);
      head_nop  = has_entry && is_nop(head);
      under_cap = (inflight < IF_W'(MAX_INFLIGHT));

      in_ready  = rdy_q && (count < CNT_W'(DEPTH)) && !flush;
      nop_drop  = head_nop && !flush;
      iss_valid = has_entry && !head_nop && under_cap && !flush;

      push  = in_valid && in_ready;
      issue = iss_valid && iss_ready;
      pop   = issue || nop_drop;

      iss_op    = head.op;
      iss_a     = W'(head.a);
      iss_b     = W'(head.b);
      iss_shamt = SH_W'(head.shamt);
      iss_tag   = TAG_W'(head.tag);
   end

   // Keeps in_ready low through reset and releases it on the first clock afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   // In-flight accounting; a completion with nothing outstanding is flagged sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
         err_cmp  <= 1'b0;
      end else begin
         unique case ({issue, cmp_valid})
            2'b10: inflight <= inflight + IF_W'(1);
            2'b01: begin
               if (inflight != '0) inflight <= inflight - IF_W'(1);
               else                err_cmp  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uop_issue_queue.sv
// Directed and random stimulus for uop_issue_queue against a queue-based reference model.
module tb_uop_issue_queue;
   import uop_pkg::*;

   localparam int unsigned W            = 64;
   localparam int unsigned DEPTH        = 4;
   localparam int unsigned TAG_W        = 4;
   localparam int unsigned MAX_INFLIGHT = 2;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   op_t          in_op;
   logic [63:0]  in_a;
   logic [63:0]  in_b;
   logic [5:0]   in_shamt;
   logic [3:0]   in_tag;
   logic         iss_valid;
   logic         iss_ready;
   op_t          iss_op;
   logic [63:0]  iss_a;
   logic [63:0]  iss_b;
   logic [5:0]   iss_shamt;
   logic [3:0]   iss_tag;
   logic         cmp_valid;
   logic [2:0]   count;
   logic [1:0]   inflight;
   logic         nop_drop;
   logic         err_cmp;

   uop_issue_queue #(
      .W            (W),
      .DEPTH        (DEPTH),
      .TAG_W        (TAG_W),
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_shamt  (in_shamt),
      .in_tag    (in_tag),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .iss_op    (iss_op),
      .iss_a     (iss_a),
      .iss_b     (iss_b),
      .iss_shamt (iss_shamt),
      .iss_tag   (iss_tag),
      .cmp_valid (cmp_valid),
      .count     (count),
      .inflight  (inflight),
      .nop_drop  (nop_drop),
      .err_cmp   (err_cmp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: queued requests, outstanding issue count, sticky error, ready-after-reset.
   uop_req_t mq[$];
   int       m_infl = 0;
   bit       m_err  = 1'b0;
   bit       m_rdy  = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic uop_req_t cur_req();
      uop_req_t r;
      r.op    = in_op;
      r.a     = in_a;
      r.b     = in_b;
      r.shamt = in_shamt;
      r.tag   = in_tag;
      return r;
   endfunction

   task automatic drive(input bit v, input op_t op, input logic [63:0] a, input logic [63:0] b,
                        input logic [5:0] sh, input logic [3:0] tag);
      in_valid = v;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_shamt = sh;
      in_tag   = tag;
   endtask

   // One clock: check outputs against the model, then advance the model across the edge.
   task automatic cycle();
      bit       e_rdy, e_nop, e_iv, do_push, do_issue, do_cmp, do_flush;
      uop_req_t req;
      #1;
      e_rdy = m_rdy && (mq.size() < int'(DEPTH)) && !flush;
      e_nop = (mq.size() > 0) && (mq[0].op == OP_NOP) && !flush;
      e_iv  = (mq.size() > 0) && (mq[0].op != OP_NOP) && (m_infl < int'(MAX_INFLIGHT)) && !flush;
      chk("in_ready",  64'(in_ready),  64'(e_rdy));
      chk("iss_valid", 64'(iss_valid), 64'(e_iv));
      chk("nop_drop",  64'(nop_drop),  64'(e_nop));
      chk("count",     64'(count),     64'(mq.size()));
      chk("inflight",  64'(inflight),  64'(m_infl));
      chk("err_cmp",   64'(err_cmp),   64'(m_err));
      if (e_iv) begin
         chk("iss_op",    64'(iss_op),    64'(mq[0].op));
         chk("iss_a",     iss_a,          mq[0].a);
         chk("iss_b",     iss_b,          mq[0].b);
         chk("iss_shamt", 64'(iss_shamt), 64'(mq[0].shamt));
         chk("iss_tag",   64'(iss_tag),   64'(mq[0].tag));
      end
      do_push  = in_valid && e_rdy;
      do_issue = e_iv && iss_ready;
      do_cmp   = cmp_valid;
      do_flush = flush;
      req      = cur_req();
      @(posedge clk);
      if (do_flush) mq.delete();
      else begin
         if (do_issue || e_nop) void'(mq.pop_front());
         if (do_push) mq.push_back(req);
      end
      if (do_issue && !do_cmp) m_infl++;
      else if (do_cmp && !do_issue) begin
         if (m_infl > 0) m_infl--;
         else            m_err = 1'b1;
      end
      m_rdy = 1'b1;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_in_ready"},  64'(in_ready),  64'd0);
      chk({pfx, "_iss_valid"}, 64'(iss_valid), 64'd0);
      chk({pfx, "_iss_op"},    64'(iss_op),    64'd0);
      chk({pfx, "_iss_a"},     iss_a,          64'd0);
      chk({pfx, "_iss_b"},     iss_b,          64'd0);
      chk({pfx, "_iss_shamt"}, 64'(iss_shamt), 64'd0);
      chk({pfx, "_iss_tag"},   64'(iss_tag),   64'd0);
      chk({pfx, "_count"},     64'(count),     64'd0);
      chk({pfx, "_inflight"},  64'(inflight),  64'd0);
      chk({pfx, "_nop_drop"},  64'(nop_drop),  64'd0);
      chk({pfx, "_err_cmp"},   64'(err_cmp),   64'd0);
   endtask

   task automatic model_reset();
      mq.delete();
      m_infl = 0;
      m_err  = 1'b0;
      m_rdy  = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      iss_ready = 1'b0;
      cmp_valid = 1'b0;
      drive(1'b0, OP_NOP, 64'd0, 64'd0, 6'd0, 4'd0);
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset_outputs("por");
      rst_n = 1'b1;
      @(posedge clk);
      m_rdy = 1'b1;
      @(negedge clk);
      chk("por_release_in_ready", 64'(in_ready), 64'd1);

      // Basic issue of one ADD.
      iss_ready = 1'b1;
      drive(1'b1, OP_ADD, 64'd5, 64'd7, 6'd3, 4'd1);
      cycle();
      drive(1'b0, OP_ADD, 64'd0, 64'd0, 6'd0, 4'd0);
      chk("basic_iss_valid", 64'(iss_valid), 64'd1);
      chk("basic_iss_a",     iss_a,          64'd5);
      chk("basic_iss_b",     iss_b,          64'd7);
      chk("basic_iss_tag",   64'(iss_tag),   64'd1);
      cycle();
      chk("basic_inflight", 64'(inflight), 64'd1);
      chk("basic_count",    64'(count),    64'd0);
      cmp_valid = 1'b1;
      cycle();
      cmp_valid = 1'b0;

      // Full FIFO with back-pressure, refused 5th push, wrap-around drain.
      iss_ready = 1'b0;
      for (int t = 0; t < 4; t++) begin
         drive(1'b1, OP_ADD, 64'(100 + t), 64'(200 + t), 6'(t), 4'(t));
         cycle();
      end
      drive(1'b1, OP_XOR, 64'd104, 64'd204, 6'd4, 4'd4);
      chk("full_count",    64'(count),    64'd4);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      iss_ready = 1'b1;
      cycle();
      chk("full_after_pop_count", 64'(count), 64'd3);
      iss_ready = 1'b0;
      cycle();
      chk("full_5th_accepted_count", 64'(count), 64'd4);
      drive(1'b0, OP_NOP, 64'd0, 64'd0, 6'd0, 4'd0);
      for (int k = 0; k < 6; k++) begin
         iss_ready = 1'b1;
         cmp_valid = (m_infl > 0);
         cycle();
      end
      cmp_valid = 1'b0;
      iss_ready = 1'b0;
      chk("full_drained_count", 64'(count), 64'd0);

      // In-flight cap of two outstanding ops.
      for (int t = 0; t < 3; t++) begin
         drive(1'b1, OP_SUB, 64'(50 + t), 64'(t), 6'd1, 4'(8 + t));
         cycle();
      end
      drive(1'b0, OP_NOP, 64'd0, 64'd0, 6'd0, 4'd0);
      iss_ready = 1'b1;
      repeat (4) cycle();
      chk("cap_inflight",  64'(inflight),  64'd2);
      chk("cap_count",     64'(count),     64'd1);
      chk("cap_iss_valid", 64'(iss_valid), 64'd0);
      cmp_valid = 1'b1;
      cycle();
      cmp_valid = 1'b0;
      chk("cap_resume_iss_valid", 64'(iss_valid), 64'd1);
      chk("cap_resume_iss_tag",   64'(iss_tag),   64'd10);
      cycle();
      chk("cap_final_inflight", 64'(inflight), 64'd2);
      chk("cap_final_count",    64'(count),    64'd0);
      cmp_valid = 1'b1;
      repeat (2) cycle();
      cmp_valid = 1'b0;

      // NOP at head is dropped without issue, then SUB issues.
      iss_ready = 1'b0;
      drive(1'b1, OP_NOP, 64'd0, 64'd0, 6'd0, 4'd3);
      cycle();
      drive(1'b1, OP_SUB, 64'd20, 64'd6, 6'd0, 4'd4);
      #1;
      chk("nop_pulse",     64'(nop_drop),  64'd1);
      chk("nop_iss_valid", 64'(iss_valid), 64'd0);
      cycle();
      drive(1'b0, OP_NOP, 64'd0, 64'd0, 6'd0, 4'd0);
      chk("nop_gone", 64'(nop_drop), 64'd0);
      iss_ready = 1'b1;
      cycle();
      iss_ready = 1'b0;
      cycle();
      chk("nop_inflight", 64'(inflight), 64'd1);

      // Flush with 3 queued and 1 in flight, then a spurious completion.
      for (int t = 0; t < 3; t++) begin
         drive(1'b1, OP_AND, 64'(t), 64'(t), 6'd0, 4'(t));
         cycle();
      end
      chk("flush_pre_count", 64'(count), 64'd3);
      flush = 1'b1;
      drive(1'b1, OP_OR, 64'd9, 64'd9, 6'd0, 4'd9);
      cycle();
      flush = 1'b0;
      drive(1'b0, OP_NOP, 64'd0, 64'd0, 6'd0, 4'd0);
      chk("flush_count",    64'(count),    64'd0);
      chk("flush_inflight", 64'(inflight), 64'd1);
      cmp_valid = 1'b1;
      repeat (2) cycle();
      cmp_valid = 1'b0;
      chk("spur_inflight", 64'(inflight), 64'd0);
      chk("spur_err",      64'(err_cmp),  64'd1);

      // Asynchronous reset while an issue is stalled.
      drive(1'b1, OP_SLL, 64'hdead_beef, 64'd1, 6'd7, 4'd5);
      cycle();
      drive(1'b0, OP_NOP, 64'd0, 64'd0, 6'd0, 4'd0);
      chk("rst_pre_iss_valid", 64'(iss_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      m_rdy = 1'b1;
      @(negedge clk);
      chk("mid_release_in_ready", 64'(in_ready), 64'd1);
      chk("mid_release_err",      64'(err_cmp),  64'd0);

      // Random traffic.
      for (int k = 0; k < 800; k++) begin
         drive(1'($urandom_range(0, 2) != 0), op_t'(4'($urandom_range(0, 8))),
               {$urandom, $urandom}, {$urandom, $urandom}, 6'($urandom), 4'($urandom));
         iss_ready = 1'($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         cmp_valid = (m_infl > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
         cycle();
      end
      flush     = 1'b0;
      cmp_valid = 1'b0;
      in_valid  = 1'b0;
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
